skew_aligner: RTL and testbench
===============================

// Module: skew_aligner
// PURPOSE
//  Parametrised multi-channel skew aligner. Each of N_CH data channels is delayed
//  by its own run-time programmable beat count, so that channels produced at
//  different pipeline depths leave the block time-aligned. Sits between the
//  integer-datapath stages and downstream consumers; adds valid qualification,
//  warm-up suppression and configuration load/flush.
// PARAMETERS
//  DATA_W   13          width of one channel sample
//  N_CH     3           number of channels
//  MAX_DLY  4           largest supported per-channel delay, in beats (>=1)
//  DLY_W    $clog2(MAX_DLY+1)   width of one delay field (derived, not overridden)
//  DEF_DLY  {N_CH{DLY_W'd0}}    per-channel delay loaded at reset; ch c = bits [c*DLY_W +: DLY_W]
// PORTS
//  clk       in   1            rising-edge clock
//  reset     in   1            synchronous, active-high reset
//  in_valid  in   1            input beat present on in_data this cycle
//  in_data   in   N_CH*DATA_W  ch c = bits [c*DATA_W +: DATA_W]
//  cfg_load  in   1            load dly_cfg and flush (single-cycle strobe)
//  dly_cfg   in   N_CH*DLY_W   requested per-channel delays
//  out_valid out  1            aligned output beat valid (registered)
//  out_data  out  N_CH*DATA_W  aligned samples, same packing as in_data (registered)
//  filling   out  1            1 while warm-up beats are still being absorbed
//  cfg_err   out  1            sticky: last load contained a field > MAX_DLY
// BEHAVIOUR
//  - Reset: out_data=0, out_valid=0, cfg_err=0, all delay-line regs=0, active
//    delays=DEF_DLY, fill counter=0, state=FILL (or RUN if max(DEF_DLY)=0).
//  - Beat-based: delay lines shift only in cycles with in_valid=1. Otherwise they
//    hold, and out_valid=0 in the next cycle.
//  - Alignment: out_data ch c for accepted beat n = in_data ch c of beat n-dly[c].
//    A delay of 0 passes the current beat. Latency is exactly 1 clk from the
//    accepting in_valid edge to the matching out_valid/out_data.
//  - out_data holds its last value while out_valid=0.
//  - State machine:
//      FILL: count accepted beats. When count reaches D = max(active dly), move to
//            RUN. out_valid is forced 0 for the first D beats. filling=1.
//      RUN:  out_valid = registered in_valid. filling=0.
//      Any state + cfg_load -> flush, then FILL (or RUN if the new D=0).
//  - cfg_load: all delay-line regs and the fill counter are cleared. Each field is
//    clamped to MAX_DLY if larger, and cfg_err is set. cfg_err clears on a load
//    with all fields legal. out_data is not cleared by a load.
//  - cfg_load with in_valid in the same cycle: the new config applies, and that
//    beat is accepted as beat 0 of the new fill. It produces out_valid only if
//    the new D=0.
//  - Flushed line contents are never emitted: warm-up suppression covers them.
//  - reset has priority over cfg_load and in_valid. Reset mid-stream discards all
//    in-flight beats with no spurious out_valid.
//  - No back-pressure: the consumer must accept every out_valid beat.
// TESTING
//  1. Reset defaults (DEF_DLY ch0=2, ch1=1, ch2=0), in_valid=1 each clk, chN data = beat idx
//     -> out_valid first high on the clk after beat 2; outputs ch2=2, ch1=1, ch0=0, then
//     all three channels advance in lockstep.
//  2. Load dly={0,0,0}, stream 5 beats -> 5 out_valid pulses, each 1 clk after its
//     input; out_data == in_data; filling never 1.
//  3. dly={4,0,3}, in_valid toggled 1,0,1,0 -> lines hold on idle cycles; alignment
//     matches the beat index, not the clk count; out_valid=0 on idle cycles.
//  4. Load dly field=7 with MAX_DLY=4 -> cfg_err=1 and the field behaves as 4. A later
//     legal load clears cfg_err.
//  5. cfg_load+in_valid in the same clk mid-RUN -> pre-load data never appears;
//     out_valid stays 0 until D new beats have been accepted.
//  6. Assert reset for 1 clk mid-stream -> next clk out_valid=0, out_data=0, filling per
//     DEF_DLY; stream resumes correctly.

Source files
------------

// File: rtl/skew_aligner.sv
// Multi-channel skew aligner: each channel is delayed by its own programmable
// number of accepted beats, with warm-up suppression and config load/flush.
module skew_aligner #(
  parameter int unsigned DATA_W  = 13,
  parameter int unsigned N_CH    = 3,
  parameter int unsigned MAX_DLY = 4,
  localparam int unsigned DLY_W  = $clog2(MAX_DLY + 1),
  parameter logic [N_CH*DLY_W-1:0] DEF_DLY = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic                   cfg_load,
  input  logic [N_CH*DLY_W-1:0]  dly_cfg,
  output logic                   out_valid,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic                   filling,
  output logic                   cfg_err
);

  localparam int unsigned DW = N_CH * DLY_W;
  localparam int unsigned BW = N_CH * DATA_W;
  localparam int unsigned LW = MAX_DLY * DATA_W;

  typedef enum logic {FILL, RUN} state_t;

  function automatic logic [DLY_W-1:0] max_dly(input logic [DW-1:0] v);
    logic [DLY_W-1:0] m;
    m = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      if (v[c*DLY_W +: DLY_W] > m) m = v[c*DLY_W +: DLY_W];
    end
    return m;
  endfunction

  localparam logic [DLY_W-1:0] DEF_MAX = max_dly(DEF_DLY);

  state_t            state_q, state_d, eff;
  logic [DLY_W-1:0]  fill_cnt, cnt_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic              err_d;
  logic              emit;
  logic [BW-1:0]     tap;
  // Per channel: entry 0 (lowest DATA_W bits) is the most recently accepted beat.
  logic [LW-1:0]     line [N_CH];

  // Next state, config update and output tap selection.
  always_comb begin
    logic [DLY_W-1:0] f;
    logic [DLY_W-1:0] sel;
    f       = '0;
    sel     = '0;
    dly_d   = dly_q;
    err_d   = cfg_err;
    cnt_d   = fill_cnt;
    eff     = state_q;
    state_d = state_q;
    emit    = 1'b0;
    tap     = '0;

    if (cfg_load) begin
      err_d = 1'b0;
      for (int c = 0; c < int'(N_CH); c++) begin
        f = dly_cfg[c*DLY_W +: DLY_W];
        if (f > DLY_W'(MAX_DLY)) begin
          f     = DLY_W'(MAX_DLY);
          err_d = 1'b1;
        end
        dly_d[c*DLY_W +: DLY_W] = f;
      end
      cnt_d   = '0;
      eff     = (max_dly(dly_d) == '0) ? RUN : FILL;
      state_d = eff;
    end

    case (eff)
      FILL: begin
        if (in_valid) begin
          cnt_d = cnt_d + DLY_W'(1);
          if (cnt_d == max_dly(dly_d)) state_d = RUN;
        end
      end
      RUN:     emit = in_valid;
      default: state_d = FILL;
    endcase

    // A flushed line reads as zero; delay 0 passes the current beat.
    for (int c = 0; c < int'(N_CH); c++) begin
      sel = dly_d[c*DLY_W +: DLY_W];
      if (sel == '0) begin
        tap[c*DATA_W +: DATA_W] = in_data[c*DATA_W +: DATA_W];
      end else begin
        for (int i = 0; i < int'(MAX_DLY); i++) begin
          if (!cfg_load && sel == DLY_W'(i + 1))
            tap[c*DATA_W +: DATA_W] = line[c][i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= (DEF_MAX == '0) ? RUN : FILL;
    else       state_q <= state_d;
  end

  // Delay lines, configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < int'(N_CH); c++) line[c] <= '0;
      dly_q     <= DEF_DLY;
      fill_cnt  <= '0;
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      filling   <= (DEF_MAX != '0);
    end else begin
      for (int c = 0; c < int'(N_CH); c++) begin
        if (in_valid)
          line[c] <= cfg_load ? LW'(in_data[c*DATA_W +: DATA_W])
                              : LW'({line[c], in_data[c*DATA_W +: DATA_W]});
        else if (cfg_load)
          line[c] <= '0;
      end
      dly_q     <= dly_d;
      fill_cnt  <= cnt_d;
      cfg_err   <= err_d;
      out_valid <= emit;
      if (emit) out_data <= tap;
      filling   <= (state_d == FILL);
    end
  end

endmodule

// File: tb/tb_skew_aligner.sv
// Randomized self-checking bench for skew_aligner against a beat-history model.
module tb_skew_aligner;

  localparam int unsigned DATA_W  = 13;
  localparam int unsigned N_CH    = 3;
  localparam int unsigned MAX_DLY = 4;
  localparam int unsigned DLY_W   = 3;
  localparam int unsigned BW      = N_CH * DATA_W;
  localparam int unsigned DW      = N_CH * DLY_W;
  localparam logic [DW-1:0] DEF   = {3'd0, 3'd1, 3'd2};

  logic          clk = 1'b0;
  logic          reset, in_valid, cfg_load;
  logic [BW-1:0] in_data;
  logic [DW-1:0] dly_cfg;
  logic          out_valid, filling, cfg_err;
  logic [BW-1:0] out_data;

  skew_aligner #(.DATA_W(DATA_W), .N_CH(N_CH), .MAX_DLY(MAX_DLY), .DEF_DLY(DEF)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .cfg_load(cfg_load), .dly_cfg(dly_cfg), .out_valid(out_valid),
    .out_data(out_data), .filling(filling), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: history of accepted beats since the last flush, indexed by beat number.
  int            m_dly [N_CH];
  int            m_d;
  int            m_n;
  logic [BW-1:0] hist [$];
  logic          e_valid, e_fill, e_err;
  logic [BW-1:0] e_data;

  wire  [BW+2:0] obs = {out_valid, filling, cfg_err, out_data};
  logic [BW+2:0] expv;

  task automatic model_edge(input logic r, input logic v, input logic ld,
                            input logic [BW-1:0] d, input logic [DW-1:0] cfg);
    int f;
    logic [BW-1:0] h;
    if (r) begin
      hist.delete();
      m_n = 0; m_d = 0;
      e_err = 1'b0; e_valid = 1'b0; e_data = '0;
      for (int c = 0; c < int'(N_CH); c++) begin
        m_dly[c] = int'(DEF[c*DLY_W +: DLY_W]);
        if (m_dly[c] > m_d) m_d = m_dly[c];
      end
      e_fill = (m_d > 0);
      return;
    end
    if (ld) begin
      hist.delete();
      m_n = 0; m_d = 0; e_err = 1'b0;
      for (int c = 0; c < int'(N_CH); c++) begin
        f = int'(cfg[c*DLY_W +: DLY_W]);
        if (f > int'(MAX_DLY)) begin
          f = int'(MAX_DLY);
          e_err = 1'b1;
        end
        m_dly[c] = f;
        if (f > m_d) m_d = f;
      end
    end
    e_valid = 1'b0;
    if (v) begin
      hist.push_back(d);
      if (m_n >= m_d) begin
        e_valid = 1'b1;
        for (int c = 0; c < int'(N_CH); c++) begin
          h = hist[m_n - m_dly[c]];
          e_data[c*DATA_W +: DATA_W] = h[c*DATA_W +: DATA_W];
        end
      end
      m_n++;
    end
    e_fill = (m_n < m_d);
  endtask

  task automatic step(input logic r, input logic v, input logic ld,
                      input logic [BW-1:0] d, input logic [DW-1:0] cfg);
    reset = r; in_valid = v; cfg_load = ld; in_data = d; dly_cfg = cfg;
    model_edge(r, v, ld, d, cfg);
    @(posedge clk);
    #1;
    expv = {e_valid, e_fill, e_err, e_data};
  endtask

  function automatic logic [BW-1:0] rnd_data();
    return BW'({$urandom(), $urandom()});
  endfunction

  task automatic test_reset();
    step(1, 0, 0, '0, '0);
    step(1, 1, 1, rnd_data(), '0);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL reset: got {v,f,e,d}=%h want %h", obs, expv);
    end
    step(0, 0, 0, '0, '0);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || filling !== 1'b1 || cfg_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got v=%b d=%h f=%b e=%b want v=0 d=0 f=1 e=0",
               out_valid, out_data, filling, cfg_err);
    end
  endtask

  task automatic test_default_stream();
    logic [BW-1:0] d;
    for (int b = 0; b < 8; b++) begin
      d = {DATA_W'(b), DATA_W'(b), DATA_W'(b)};
      step(0, 1, 0, d, '0);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL default_stream beat %0d: got %h want %h", b, obs, expv);
      end
      if (b == 2) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== {13'd2, 13'd1, 13'd0}) begin
          n_bad++;
          $display("FAIL default_first: got v=%b d=%h want v=1 d=%h",
                   out_valid, out_data, {13'd2, 13'd1, 13'd0});
        end
      end
    end
  endtask

  task automatic test_zero_delay();
    logic [BW-1:0] d;
    step(0, 0, 1, '0, '0);
    for (int b = 0; b < 5; b++) begin
      d = rnd_data();
      step(0, 1, 0, d, '0);
      n_cmp++;
      if (obs !== expv || out_valid !== 1'b1 || out_data !== d || filling !== 1'b0) begin
        n_bad++;
        $display("FAIL zero_delay beat %0d: got %h want %h (in %h)", b, obs, expv, d);
      end
    end
  endtask

  task automatic test_toggle();
    step(0, 0, 1, '0, {3'd4, 3'd0, 3'd3});
    for (int i = 0; i < 24; i++) begin
      step(0, (i % 2) == 0, 0, rnd_data(), '0);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL toggle cycle %0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_clamp();
    step(0, 0, 1, '0, {3'd0, 3'd7, 3'd1});
    n_cmp++;
    if (cfg_err !== 1'b1 || obs !== expv) begin
      n_bad++;
      $display("FAIL clamp_err: got %h want %h", obs, expv);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, rnd_data(), '0);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL clamp_stream %0d: got %h want %h", i, obs, expv);
      end
    end
    step(0, 0, 1, '0, {3'd2, 3'd0, 3'd0});
    n_cmp++;
    if (cfg_err !== 1'b0 || obs !== expv) begin
      n_bad++;
      $display("FAIL clamp_clear: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_load_mid_run();
    step(0, 0, 1, '0, {3'd1, 3'd0, 3'd2});
    for (int i = 0; i < 5; i++) step(0, 1, 0, rnd_data(), '0);
    step(0, 1, 1, rnd_data(), {3'd2, 3'd3, 3'd1});
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL load_mid_run %0d: got %h want %h", i, obs, expv);
      end
      step(0, 1, 0, rnd_data(), '0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(0, 1, 0, rnd_data(), '0);
    step(1, 1, 0, rnd_data(), '0);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || filling !== 1'b1 || obs !== expv) begin
      n_bad++;
      $display("FAIL reset_mid: got %h want %h", obs, expv);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, rnd_data(), '0);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL reset_resume %0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_random();
    logic r, v, ld;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom % 50) == 0;
      ld = ($urandom % 20) == 0;
      v  = ($urandom % 4) != 0;
      step(r, v, ld, rnd_data(), DW'($urandom));
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL random cycle %0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; cfg_load = 1'b0; in_data = '0; dly_cfg = '0;
    test_reset();
    test_default_stream();
    test_zero_delay();
    test_toggle();
    test_clamp();
    test_load_mid_run();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
